// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for the shared execute ALU.
// Issue register feeds the ALU; results land in per-port 2-entry FIFOs.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE,
    ALU_MTC0_PASS, ALU_MTC0_FAIL
  } AluCtl;
  typedef enum logic {NOT_TAKEN, TAKEN} BranchOutcome;
  typedef enum logic [1:0] {
    MTC0_NOOP, MTC0_PASS, MTC0_FAIL
  } Mtc0Code;
endpackage

interface pass_done_ifc #(
  parameter int W = `DATA_WIDTH
);
  import alu_arbiter_pkg::*;
  Mtc0Code        code;
  logic [W-1:0]   value;
  modport out (output code, value);
  modport mon (input code, value);
endinterface

module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  valid,
  input  AluCtl                 alu_ctl,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic                  is_ll,
  input  logic                  is_sc,
  input  logic                  is_sw,
  output logic [DATA_WIDTH-1:0] result,
  output BranchOutcome          branch_outcome,
  pass_done_ifc.out             pass_done
);
  localparam int SHW = $clog2(DATA_WIDTH);
  Mtc0Code               code;
  logic [DATA_WIDTH-1:0] res;
  logic                  slt;
  logic                  sltu;

  assign slt  = $signed(op1) < $signed(op2);
  assign sltu = op1 < op2;

  // Datapath, branch compare and MTC0 report decode
  always_comb begin
    res            = '0;
    branch_outcome = NOT_TAKEN;
    code           = MTC0_NOOP;
    case (alu_ctl)
      ALU_ADD:  res = op1 + op2;
      ALU_SUB:  res = op1 - op2;
      ALU_AND:  res = op1 & op2;
      ALU_OR:   res = op1 | op2;
      ALU_XOR:  res = op1 ^ op2;
      ALU_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, slt};
      ALU_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, sltu};
      ALU_SLL:  res = op1 << op2[SHW-1:0];
      ALU_SRL:  res = op1 >> op2[SHW-1:0];
      ALU_BEQ:
        branch_outcome = (op1 == op2) ? TAKEN : NOT_TAKEN;
      ALU_BNE:
        branch_outcome = (op1 != op2) ? TAKEN : NOT_TAKEN;
      ALU_BLT:
        branch_outcome = slt ? TAKEN : NOT_TAKEN;
      ALU_BGE:
        branch_outcome = slt ? NOT_TAKEN : TAKEN;
      ALU_MTC0_PASS: begin
        res  = op2;
        code = MTC0_PASS;
      end
      ALU_MTC0_FAIL: begin
        res  = op2;
        code = MTC0_FAIL;
      end
      default: res = '0;
    endcase
    if (is_ll || is_sw) res = op1 + op2;
    if (is_sc) res = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    if (!valid) code = MTC0_NOOP;
  end

  assign result          = res;
  assign pass_done.code  = code;
  assign pass_done.value = (code != MTC0_NOOP) ? op2 : '0;
endmodule

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  AluCtl [1:0]                req_alu_ctl,
  input  logic [1:0][DATA_WIDTH-1:0] req_op1,
  input  logic [1:0][DATA_WIDTH-1:0] req_op2,
  input  logic [1:0][TAG_WIDTH-1:0]  req_tag,
  input  logic [1:0]                 flush,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [1:0][DATA_WIDTH-1:0] rsp_result,
  output BranchOutcome [1:0]         rsp_branch_outcome,
  output logic [1:0][TAG_WIDTH-1:0]  rsp_tag,
  pass_done_ifc.out                  pass_done
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] res;
    BranchOutcome          br;
    logic [TAG_WIDTH-1:0]  tag;
  } ent_t;

  logic                  ptr_q, ptr_d;
  logic                  iss_vld_q, iss_vld_d;
  logic                  iss_own_q, iss_own_d;
  AluCtl                 iss_ctl_q, iss_ctl_d;
  logic [DATA_WIDTH-1:0] iss_op1_q, iss_op1_d;
  logic [DATA_WIDTH-1:0] iss_op2_q, iss_op2_d;
  logic [TAG_WIDTH-1:0]  iss_tag_q, iss_tag_d;
  ent_t [1:0][1:0]       fifo_q, fifo_d;
  logic [1:0][1:0]       cnt_q, cnt_d;

  logic [1:0]            pop;
  logic [1:0]            push;
  logic [1:0]            elig;
  logic [1:0]            gnt;
  logic [1:0][2:0]       outs;
  logic [DATA_WIDTH-1:0] alu_res;
  BranchOutcome          alu_br;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .valid          (iss_vld_q),
    .alu_ctl        (iss_ctl_q),
    .op1            (iss_op1_q),
    .op2            (iss_op2_q),
    .is_ll          (1'b0),
    .is_sc          (1'b0),
    .is_sw          (1'b0),
    .result         (alu_res),
    .branch_outcome (alu_br),
    .pass_done      (pass_done)
  );

  // Per-port outstanding count, pop/push and eligibility
  always_comb begin
    pop  = '0;
    push = '0;
    elig = '0;
    outs = '0;
    for (int i = 0; i < 2; i++) begin
      pop[i]  = rsp_valid[i] && rsp_ready[i];
      push[i] = iss_vld_q && (iss_own_q == 1'(i))
                && !flush[i];
      outs[i] = {1'b0, cnt_q[i]}
              + {2'b0, iss_vld_q && (iss_own_q == 1'(i))};
      elig[i] = req_valid[i] && !flush[i]
              && ((outs[i] - {2'b0, pop[i]}) < 3'd2);
    end
  end

  // Round-robin grant, suppressed during reset
  always_comb begin
    gnt = 2'b00;
    priority case (1'b1)
      rst:            gnt = 2'b00;
      (elig == 2'b11): gnt = ptr_q ? 2'b10 : 2'b01;
      elig[0]:        gnt = 2'b01;
      elig[1]:        gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  // Next pointer, issue register and FIFO contents
  always_comb begin
    ptr_d     = (gnt != 2'b00) ? gnt[0] : ptr_q;
    iss_vld_d = |gnt;
    iss_own_d = gnt[1];
    iss_ctl_d = req_alu_ctl[gnt[1]];
    iss_op1_d = req_op1[gnt[1]];
    iss_op2_d = req_op2[gnt[1]];
    iss_tag_d = req_tag[gnt[1]];
    fifo_d    = fifo_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (pop[i]) begin
        fifo_d[i][0] = fifo_q[i][1];
        cnt_d[i]     = cnt_q[i] - 2'd1;
      end
      if (push[i]) begin
        fifo_d[i][cnt_d[i][0]] = '{
          res: alu_res, br: alu_br, tag: iss_tag_q};
        cnt_d[i] = cnt_d[i] + 2'd1;
      end
      if (flush[i]) cnt_d[i] = 2'd0;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= 1'b0;
      iss_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      iss_vld_q <= iss_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  // Payload registers need no reset; valid bits guard them
  always_ff @(posedge clk) begin
    iss_own_q <= iss_own_d;
    iss_ctl_q <= iss_ctl_d;
    iss_op1_q <= iss_op1_d;
    iss_op2_q <= iss_op2_d;
    iss_tag_q <= iss_tag_d;
    fifo_q    <= fifo_d;
  end

  assign req_ready = gnt;

  // FIFO heads drive the response ports
  always_comb begin
    rsp_valid          = '0;
    rsp_result         = '0;
    rsp_branch_outcome = {NOT_TAKEN, NOT_TAKEN};
    rsp_tag            = '0;
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i]          = cnt_q[i] != 2'd0;
      rsp_result[i]         = fifo_q[i][0].res;
      rsp_branch_outcome[i] = fifo_q[i][0].br;
      rsp_tag[i]            = fifo_q[i][0].tag;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbiter.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
  localparam int DW = 16;
  localparam int TW = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  AluCtl [1:0]         req_alu_ctl;
  logic [1:0][DW-1:0]  req_op1;
  logic [1:0][DW-1:0]  req_op2;
  logic [1:0][TW-1:0]  req_tag;
  logic [1:0]          flush;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [1:0][DW-1:0]  rsp_result;
  BranchOutcome [1:0]  rsp_branch_outcome;
  logic [1:0][TW-1:0]  rsp_tag;

  pass_done_ifc #(.W(DW)) pd ();

  alu_arbiter #(.TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_alu_ctl        (req_alu_ctl),
    .req_op1            (req_op1),
    .req_op2            (req_op2),
    .req_tag            (req_tag),
    .flush              (flush),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_result         (rsp_result),
    .rsp_branch_outcome (rsp_branch_outcome),
    .rsp_tag            (rsp_tag),
    .pass_done          (pd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    BranchOutcome  br;
    logic [TW-1:0] tag;
  } rsp_t;

  rsp_t          mq [2][$];
  logic          mptr;
  logic          mi_v;
  logic          mi_own;
  AluCtl         mi_ctl;
  logic [DW-1:0] mi_b;
  rsp_t          mi_rsp;
  logic [1:0]    obs_gnt;
  logic [1:0]    exp_gnt;
  int            checks = 0;
  int            failures = 0;

  function automatic rsp_t ref_alu(AluCtl c, logic [DW-1:0] a,
                                   logic [DW-1:0] b, logic [TW-1:0] t);
    rsp_t r;
    r.res = '0;
    r.br  = NOT_TAKEN;
    r.tag = t;
    case (c)
      ALU_ADD:  r.res = a + b;
      ALU_SUB:  r.res = a - b;
      ALU_AND:  r.res = a & b;
      ALU_OR:   r.res = a | b;
      ALU_XOR:  r.res = a ^ b;
      ALU_SLT:  r.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      ALU_SLTU: r.res = (a < b) ? 16'd1 : 16'd0;
      ALU_SLL:  r.res = a << (b % 16);
      ALU_SRL:  r.res = a >> (b % 16);
      ALU_BEQ:  r.br = (a == b) ? TAKEN : NOT_TAKEN;
      ALU_BNE:  r.br = (a != b) ? TAKEN : NOT_TAKEN;
      ALU_BLT:  r.br = ($signed(a) < $signed(b)) ? TAKEN : NOT_TAKEN;
      ALU_BGE:  r.br = ($signed(a) >= $signed(b)) ? TAKEN : NOT_TAKEN;
      ALU_MTC0_PASS, ALU_MTC0_FAIL: r.res = b;
      default: r.res = '0;
    endcase
    return r;
  endfunction

  function automatic Mtc0Code exp_code();
    if (!mi_v) return MTC0_NOOP;
    if (mi_ctl == ALU_MTC0_PASS) return MTC0_PASS;
    if (mi_ctl == ALU_MTC0_FAIL) return MTC0_FAIL;
    return MTC0_NOOP;
  endfunction

  task automatic set_op(input int p, input AluCtl c,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] t);
    req_alu_ctl[p] = c;
    req_op1[p]     = a;
    req_op2[p]     = b;
    req_tag[p]     = t;
  endtask

  // One clock: drive inputs, record grant, advance model past the edge.
  task automatic cycle(input logic [1:0] rv, input logic [1:0] rr,
                       input logic [1:0] fl);
    logic [1:0] pp;
    logic [1:0] eg;
    logic [1:0] g;
    int         oc;
    int         sel;
    req_valid = rv;
    rsp_ready = rr;
    flush     = fl;
    for (int i = 0; i < 2; i++) begin
      pp[i] = (mq[i].size() > 0) && rr[i];
      oc    = mq[i].size() + ((mi_v && mi_own == 1'(i)) ? 1 : 0);
      eg[i] = rv[i] && !fl[i] && ((oc - int'(pp[i])) < 2);
    end
    g = 2'b00;
    if (!rst) begin
      if (eg == 2'b11) g[mptr] = 1'b1;
      else g = eg;
    end
    #1;
    obs_gnt = req_ready;
    exp_gnt = g;
    @(posedge clk);
    if (rst) begin
      mq[0].delete();
      mq[1].delete();
      mptr = 1'b0;
      mi_v = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fl[i]) mq[i].delete();
        else begin
          if (pp[i]) void'(mq[i].pop_front());
          if (mi_v && mi_own == 1'(i)) mq[i].push_back(mi_rsp);
        end
      end
      if (g != 2'b00) mptr = g[0];
      sel    = g[1] ? 1 : 0;
      mi_v   = |g;
      mi_own = g[1];
      mi_ctl = req_alu_ctl[sel];
      mi_b   = req_op2[sel];
      mi_rsp = ref_alu(req_alu_ctl[sel], req_op1[sel],
                       req_op2[sel], req_tag[sel]);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(2'b00, 2'b00, 2'b00);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(2'b11, 2'b00, 2'b00);
    checks++;
    if (obs_gnt !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=00", obs_gnt);
    end
    cycle(2'b11, 2'b00, 2'b00);
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid);
    end
    checks++;
    if (pd.code !== MTC0_NOOP) begin
      failures++;
      $display("FAIL reset_pass_code got=%0d exp=%0d", pd.code, MTC0_NOOP);
    end
  endtask

  task automatic test_single_add();
    set_op(0, ALU_ADD, 16'd5, 16'd7, 4'd3);
    cycle(2'b01, 2'b11, 2'b00);
    checks++;
    if (obs_gnt !== 2'b01) begin
      failures++;
      $display("FAIL add_grant got=%b exp=01", obs_gnt);
    end
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL add_early got=%b exp=00", rsp_valid);
    end
    cycle(2'b00, 2'b11, 2'b00);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result[0] !== 16'd12 ||
        rsp_tag[0] !== 4'd3 || rsp_branch_outcome[0] !== NOT_TAKEN) begin
      failures++;
      $display("FAIL add_rsp got=%b/%0d/%0d/%0d exp=01/12/3/0",
               rsp_valid, rsp_result[0], rsp_tag[0], rsp_branch_outcome[0]);
    end
    cycle(2'b00, 2'b11, 2'b00);
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL add_pop got=%b exp=00", rsp_valid);
    end
  endtask

  task automatic test_alternate();
    int n0;
    int n1;
    n0 = 0;
    n1 = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_op(0, ALU_SUB, 16'd10, 16'd3, 4'(k));
      set_op(1, ALU_BEQ, 16'd4, 16'd4, 4'(k));
      cycle(2'b11, 2'b11, 2'b00);
      checks++;
      if (obs_gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL alt_grant k=%0d got=%b", k, obs_gnt);
      end
      if (rsp_valid[0]) begin
        n0++;
        checks++;
        if (rsp_result[0] !== 16'd7) begin
          failures++;
          $display("FAIL alt_sub got=%0d exp=7", rsp_result[0]);
        end
      end
      if (rsp_valid[1]) begin
        n1++;
        checks++;
        if (rsp_branch_outcome[1] !== TAKEN) begin
          failures++;
          $display("FAIL alt_beq got=%0d exp=%0d",
                   rsp_branch_outcome[1], TAKEN);
        end
      end
    end
    checks++;
    if (n0 != 4 || n1 != 3) begin
      failures++;
      $display("FAIL alt_count got=%0d/%0d exp=4/3", n0, n1);
    end
    cycle(2'b00, 2'b11, 2'b00);
    cycle(2'b00, 2'b11, 2'b00);
  endtask

  task automatic test_backpressure();
    int n1;
    n1 = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_op(0, ALU_ADD, 16'(k), 16'd1, 4'(k));
      set_op(1, ALU_XOR, 16'(k), 16'd3, 4'(k + 8));
      cycle(2'b11, 2'b01, 2'b00);
      if (obs_gnt[1]) n1++;
      if (k >= 4) begin
        checks++;
        if (obs_gnt !== 2'b01) begin
          failures++;
          $display("FAIL bp_p0_only k=%0d got=%b exp=01", k, obs_gnt);
        end
      end
    end
    checks++;
    if (n1 != 2) begin
      failures++;
      $display("FAIL bp_p1_grants got=%0d exp=2", n1);
    end
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_tag[1] !== 4'd9) begin
      failures++;
      $display("FAIL bp_head0 got=%b/%0d exp=1/9", rsp_valid[1], rsp_tag[1]);
    end
    cycle(2'b01, 2'b11, 2'b00);
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_tag[1] !== 4'd11) begin
      failures++;
      $display("FAIL bp_head1 got=%b/%0d exp=1/11", rsp_valid[1], rsp_tag[1]);
    end
    cycle(2'b01, 2'b11, 2'b00);
    checks++;
    if (rsp_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained got=%b exp=0", rsp_valid[1]);
    end
    cycle(2'b11, 2'b11, 2'b00);
    checks++;
    if (obs_gnt !== 2'b10) begin
      failures++;
      $display("FAIL bp_resume got=%b exp=10", obs_gnt);
    end
    for (int k = 0; k < 3; k++) cycle(2'b00, 2'b11, 2'b00);
  endtask

  task automatic test_flush();
    do_reset();
    set_op(0, ALU_SLT, 16'hFFFF, 16'd0, 4'd2);
    cycle(2'b01, 2'b00, 2'b00);
    set_op(1, ALU_ADD, 16'd1, 16'd1, 4'd6);
    cycle(2'b10, 2'b00, 2'b00);
    set_op(1, ALU_ADD, 16'd2, 16'd2, 4'd7);
    cycle(2'b10, 2'b00, 2'b00);
    checks++;
    if (rsp_valid !== 2'b11) begin
      failures++;
      $display("FAIL fl_setup got=%b exp=11", rsp_valid);
    end
    cycle(2'b10, 2'b10, 2'b10);
    checks++;
    if (obs_gnt !== 2'b00) begin
      failures++;
      $display("FAIL fl_nogrant got=%b exp=00", obs_gnt);
    end
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result[0] !== 16'd1 ||
        rsp_tag[0] !== 4'd2) begin
      failures++;
      $display("FAIL fl_after got=%b/%0d/%0d exp=01/1/2",
               rsp_valid, rsp_result[0], rsp_tag[0]);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(2'b00, 2'b11, 2'b00);
      checks++;
      if (rsp_valid[1] !== 1'b0) begin
        failures++;
        $display("FAIL fl_ghost k=%0d got=1 exp=0", k);
      end
    end
  endtask

  task automatic test_mtc0();
    checks++;
    if (pd.code !== MTC0_NOOP) begin
      failures++;
      $display("FAIL mtc0_idle got=%0d exp=%0d", pd.code, MTC0_NOOP);
    end
    set_op(0, ALU_MTC0_PASS, 16'd0, 16'h0042, 4'd5);
    cycle(2'b01, 2'b11, 2'b00);
    checks++;
    if (pd.code !== MTC0_PASS || pd.value !== 16'h0042) begin
      failures++;
      $display("FAIL mtc0_report got=%0d/%h exp=%0d/0042",
               pd.code, pd.value, MTC0_PASS);
    end
    cycle(2'b00, 2'b11, 2'b00);
    checks++;
    if (pd.code !== MTC0_NOOP) begin
      failures++;
      $display("FAIL mtc0_once got=%0d exp=%0d", pd.code, MTC0_NOOP);
    end
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_tag[0] !== 4'd5 ||
        rsp_result[0] !== 16'h0042) begin
      failures++;
      $display("FAIL mtc0_rsp got=%b/%0d/%h exp=1/5/0042",
               rsp_valid[0], rsp_tag[0], rsp_result[0]);
    end
    cycle(2'b00, 2'b11, 2'b00);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_op(0, ALU_ADD, 16'(k), 16'(k), 4'(k));
      set_op(1, ALU_OR, 16'(k), 16'd8, 4'(k));
      cycle(2'b11, 2'b00, 2'b00);
    end
    checks++;
    if (rsp_valid !== 2'b11 || obs_gnt !== 2'b00) begin
      failures++;
      $display("FAIL rm_full got=%b/%b exp=11/00", rsp_valid, obs_gnt);
    end
    rst = 1'b1;
    cycle(2'b11, 2'b00, 2'b00);
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL rm_cleared got=%b exp=00", rsp_valid);
    end
    set_op(0, ALU_ADD, 16'd1, 16'd2, 4'hA);
    set_op(1, ALU_ADD, 16'd3, 16'd4, 4'hB);
    cycle(2'b11, 2'b11, 2'b00);
    checks++;
    if (obs_gnt !== 2'b01) begin
      failures++;
      $display("FAIL rm_first_grant got=%b exp=01", obs_gnt);
    end
    cycle(2'b00, 2'b11, 2'b00);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_tag[0] !== 4'hA ||
        rsp_result[0] !== 16'd3) begin
      failures++;
      $display("FAIL rm_new_rsp got=%b/%h/%0d exp=01/a/3",
               rsp_valid, rsp_tag[0], rsp_result[0]);
    end
    cycle(2'b00, 2'b11, 2'b00);
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL rm_no_stale got=%b exp=00", rsp_valid);
    end
  endtask

  task automatic test_random();
    logic [1:0]    rr;
    logic [1:0]    fl;
    Mtc0Code       ec;
    logic [DW-1:0] ev;
    for (int k = 0; k < 600; k++) begin
      for (int p = 0; p < 2; p++)
        set_op(p, AluCtl'(4'($urandom_range(0, 14))),
               16'($urandom), 16'($urandom), 4'($urandom));
      rr[0] = $urandom_range(0, 3) != 0;
      rr[1] = $urandom_range(0, 3) != 0;
      fl    = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      rst   = $urandom_range(0, 99) == 0;
      cycle(2'($urandom), rr, fl);
      rst = 1'b0;
      checks++;
      if (obs_gnt !== exp_gnt) begin
        failures++;
        $display("FAIL rnd_grant k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt);
      end
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rsp_valid[p] !== (mq[p].size() != 0)) begin
          failures++;
          $display("FAIL rnd_valid k=%0d p=%0d got=%b exp=%0d",
                   k, p, rsp_valid[p], mq[p].size());
        end
        if (mq[p].size() != 0) begin
          checks++;
          if (rsp_result[p] !== mq[p][0].res ||
              rsp_branch_outcome[p] !== mq[p][0].br ||
              rsp_tag[p] !== mq[p][0].tag) begin
            failures++;
            $display("FAIL rnd_head k=%0d p=%0d got=%h/%0d/%h exp=%h/%0d/%h",
                     k, p, rsp_result[p], rsp_branch_outcome[p], rsp_tag[p],
                     mq[p][0].res, mq[p][0].br, mq[p][0].tag);
          end
        end
      end
      ec = exp_code();
      ev = (ec != MTC0_NOOP) ? mi_b : '0;
      checks++;
      if (pd.code !== ec || pd.value !== ev) begin
        failures++;
        $display("FAIL rnd_pass k=%0d got=%0d/%h exp=%0d/%h",
                 k, pd.code, pd.value, ec, ev);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    flush     = 2'b00;
    req_alu_ctl = {ALU_ADD, ALU_ADD};
    req_op1   = '0;
    req_op2   = '0;
    req_tag   = '0;
    mptr      = 1'b0;
    mi_v      = 1'b0;
    mi_own    = 1'b0;
    mi_ctl    = ALU_ADD;
    mi_b      = '0;
    mi_rsp    = '{res: '0, br: NOT_TAKEN, tag: '0};
    @(negedge clk);
    test_reset();
    test_single_add();
    test_alternate();
    test_backpressure();
    test_flush();
    test_mtc0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the execution-stage `alu` between two requesters (port 0: main execute pipe; port 1: secondary issue source, e.g. a multi-cycle sequencer) with round-robin arbitration. It registers the granted operation into an issue stage, lets the ALU evaluate it combinationally, and captures the result into a per-port 2-entry response FIFO with valid/ready backpressure and per-port flush. The block sits in the execute stage, between the issue logic and the writeback/branch-resolution consumers.

## Interface
Parameters:
- `TAG_WIDTH`, 4: width of the opaque requester tag returned with each result.
- `DATA_WIDTH`, `` `DATA_WIDTH ``: operand/result width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid[1:0]`  in  2  per-port request valid.
- `req_ready[1:0]`  out  2  per-port grant; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `req_alu_ctl[i]`  in  AluCtl  operation per port.
- `req_op1[i]`, `req_op2[i]`  in  DATA_WIDTH each  operands per port.
- `req_tag[i]`  in  TAG_WIDTH  tag per port.
- `flush[1:0]`  in  2  per-port drop of all in-flight work.
- `rsp_valid[1:0]`  out  2  response FIFO head valid.
- `rsp_ready[1:0]`  in  2  consumer pop.
- `rsp_result[i]`  out  DATA_WIDTH  ALU result.
- `rsp_branch_outcome[i]`  out  BranchOutcome  branch resolution.
- `rsp_tag[i]`  out  TAG_WIDTH  echoed tag.
- `pass_done`  pass_done_ifc.out  MTC0 reporting, driven directly by the internal ALU.

## Operation
- State: priority pointer `ptr` (1 bit); issue register {valid, owner, alu_ctl, op1, op2, tag}; two 2-entry FIFOs {result, branch_outcome, tag}.
- Per-port outstanding count `out_i` = (issue valid && owner==i) + FIFO_i occupancy; range 0..2.
- Eligibility: `elig_i = req_valid[i] && !flush[i] && (out_i - pop_i) < 2`, where `pop_i = rsp_valid[i] && rsp_ready[i]`. This bound guarantees that no FIFO ever overflows.
- Grant: if both ports are eligible, grant port `ptr`; if only one is eligible, grant it. At most one grant per cycle. `req_ready[i]` = grant_i (combinational) and is 0 while `rst`.
- After any grant to port g: `ptr <= ~g`. With no grant, `ptr` holds.
- Issue register loads the granted request every cycle; its valid bit follows the grant. The ALU input is driven from the issue register (`valid`, `alu_ctl`, `op1`, `op2`; `is_ll/is_sc/is_sw` tied 0).
- The ALU output (when the issue register is valid) pushes into FIFO[owner] at the next edge, together with the issue tag.
- FIFO: head drives the `rsp_*` outputs. Push and pop in the same cycle are legal, including when the FIFO is full (pop frees the slot first).
- `flush[i]` (sampled at edge): FIFO_i cleared, issue register invalidated if owner==i (no push, no ALU side effect on the next cycle), and no grant to i that cycle. Port j≠i and `ptr` are unaffected.
- `pass_done` is a pure pass-through from the ALU. MTC0 ops from either port report once, in the cycle they occupy the issue register.

## Timing
- Reset (edge with `rst`=1): `ptr`=0, issue valid=0, both FIFOs empty, `rsp_valid`=2'b00, `req_ready`=2'b00. The `pass_done.code` idle state is MTC0_NOOP.
- Latency: request accepted at edge N → ALU evaluates during cycle N..N+1 → `rsp_valid[i]`=1 after edge N+1 (2 edges, request to response).
- Throughput: 1 op/cycle total. A single port with `rsp_ready` held 1 sustains 1 op/cycle.
- `rsp_ready`=0 on port i: port i stalls after 2 outstanding ops. The other port still gets every cycle.
- Simultaneous flush[i] and pop_i: flush wins; the FIFO ends empty.
- `rst` asserted mid-operation discards issue and FIFO contents at that edge. No response for the discarded ops is ever produced.

## Test plan
- Reset, then a port 0 ADD with op1=5, op2=7, tag=3 → `req_ready[0]`=1 in that cycle; `rsp_valid[0]`=1 exactly 2 edges later with result=12, tag=3, branch_outcome=NOT_TAKEN.
- Both ports request every cycle, `rsp_ready`=2'b11 → grants alternate 0,1,0,1 starting with port 0 after reset. Port 0 SUB 10-3 → 7; port 1 BEQ 4,4 → TAKEN.
- Port 1 `rsp_ready`=0 while port 1 requests continuously → exactly 2 grants to port 1, then `req_ready[1]`=0. Port 0 is granted every cycle. Raising `rsp_ready[1]` drains tags in order and grants resume.
- `flush[1]` asserted while port 1 has an op in the issue register and 1 entry in its FIFO → `rsp_valid[1]`=0 after the edge and no port 1 response ever appears. An in-flight port 0 op (SLT -1,0 → 1) completes normally.
- Port 0 issues an MTC0_PASS op with op2=16'h0042 → `pass_done.code`=MTC0_PASS, value=16'h0042 for exactly one cycle, and a port 0 response is still produced.
- `rst` pulsed while both FIFOs hold 2 entries → all `rsp_valid` are 0 next cycle, `ptr`=0, and the first post-reset contention grants port 0.
